iram_prog: RTL and testbench
============================

// Module: iram_prog
// PURPOSE
//  Parametrised, field-programmable instruction memory for the two-counter machine core.
//  - After reset it sweeps the whole array to FILL_WORD.
//  - It then accepts a program over a valid/ready load port.
//  - It then serves registered fetches to the sequencer.
//  REPROG wipes and reloads the memory at run time, so programs are no longer hard-coded at reset.
// PARAMETERS
//  DATA_W     8     instruction word width
//  ADDR_W     8     address width of the fetch and load ports
//  DEPTH      128   implemented words; legal range 1..2**ADDR_W
//  FILL_WORD  0     clear value; also returned for out-of-range fetches (0 = NOP)
// PORTS
//  CLK       in   1       rising-edge clock
//  RESET     in   1       asynchronous, active-low reset
//  LD_VALID  in   1       load word offered
//  LD_READY  out  1       loader can accept a word (high only in LOAD)
//  LD_ADDR   in   ADDR_W  load address
//  LD_DATA   in   DATA_W  load data
//  LD_LAST   in   1       qualifies the final load word; accepting it enters RUN
//  REPROG    in   1       in RUN: discard the program and restart the clear sweep
//  RD_EN     in   1       fetch request (honoured only in RUN)
//  ADDR      in   ADDR_W  fetch address
//  Q         out  DATA_W  fetched word, registered
//  Q_VALID   out  1       Q updated by the previous cycle's fetch
//  RUN       out  1       memory programmed, fetches honoured
//  LD_ERR    out  1       sticky: an out-of-range load address was accepted
// BEHAVIOUR
//  Reset (RESET low, async assert; release sampled on CLK)
//  - state=CLEAR, clr_ptr=0, Q=0, Q_VALID=0, RUN=0, LD_READY=0, LD_ERR=0.
//  - Array contents are not reset; the sweep overwrites them.
//  CLEAR
//  - Writes mem[clr_ptr]=FILL_WORD each cycle, clr_ptr 0..DEPTH-1.
//  - At clr_ptr==DEPTH-1: goes to LOAD and clr_ptr returns to 0.
//  - Takes exactly DEPTH cycles; LD_READY rises on cycle DEPTH after reset release.
//  LOAD
//  - LD_READY=1. A handshake is LD_VALID&LD_READY on a rising edge.
//  - On a handshake with LD_ADDR<DEPTH: mem[LD_ADDR]<=LD_DATA.
//  - On a handshake with LD_ADDR>=DEPTH: the write is dropped (no aliasing) and LD_ERR<=1.
//  - A handshake with LD_LAST=1 enters RUN on the next cycle. This holds even if that word was dropped.
//  - LD_VALID with LD_READY low: no effect; the source must hold its word.
//  - Unwritten words keep FILL_WORD.
//  RUN
//  - RUN=1, LD_READY=0, load port ignored.
//  - Fetch: RD_EN=1 at edge N gives Q=mem[ADDR] and Q_VALID=1 after edge N (1-cycle latency).
//  - Back-to-back fetches give one word per cycle.
//  - Out-of-range ADDR (>=DEPTH): Q=FILL_WORD, Q_VALID=1.
//  - RD_EN=0: Q holds its last value, Q_VALID=0.
//  - REPROG=1: goes to CLEAR next cycle, RUN<=0, LD_ERR<=0.
//  - REPROG and RD_EN together: REPROG wins, the fetch is dropped, Q_VALID=0.
//  Outside RUN
//  - RD_EN is ignored, Q_VALID=0, Q holds.
//  - REPROG is ignored in CLEAR/LOAD.
//  Other rules
//  - Reset mid-sweep or mid-load: immediate return to reset values; the sweep restarts from 0.
//  - The only legal transition order is CLEAR -> LOAD -> RUN -> CLEAR.
//  - Fetch and load never overlap, so the array needs one write port and one registered read port.
// TESTING
//  1. Release reset -> LD_READY=0 for 128 cycles, then 1. Read-back after loading nothing shows all words 0x00.
//  2. Load the 14-word subtract program (0x40 x5, 0x50 x2, 0xB4, 0x70, 0x60, 0xC5, 0x90, 0x30, 0xE0; LAST on 0xE0).
//     -> RUN=1; fetch 7 gives 0xB4; fetch 13 gives 0xE0; fetch 20 gives 0x00; each Q_VALID one cycle after RD_EN.
//  3. Load with LD_VALID toggling and gaps -> only handshaken words land; LD_ERR stays 0.
//  4. Load addr 200 data 0xFF (DEPTH=128), then LAST -> LD_ERR=1; fetch 72 gives 0x00; fetch 200 gives 0x00 with Q_VALID=1.
//  5. In RUN, assert REPROG with RD_EN -> Q_VALID=0, RUN=0, LD_ERR=0; after 128 cycles LD_READY=1 and old words read 0x00.
//  6. Assert reset at sweep cycle 50 and mid-load -> outputs return to reset values at once; full 128-cycle sweep repeats.
//     Repeat scenario 2 with DATA_W=16, DEPTH=256.

Source files
------------

// File: rtl/iram_prog.sv
// Field-programmable instruction memory: clear sweep, then valid/ready program load, then 1-cycle registered fetch.
// Load port accepts only in LOAD (LD_READY), the source holds its word otherwise; fetches are honoured only in RUN.
module iram_prog #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 8,
  parameter int                 DEPTH     = 128,
  parameter logic [DATA_W-1:0]  FILL_WORD = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_LAST,
  input  logic              REPROG,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  output logic              RUN,
  output logic              LD_ERR
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  clr_ptr, clr_ptr_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [PTR_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic              ld_hs;
  logic              ld_addr_ok;
  logic              rd_addr_ok;
  logic              fetch_go;

  // Range checks are done at full address width so out-of-range words never alias.
  assign ld_addr_ok = ({1'b0, LD_ADDR} < DEPTH_V);
  assign rd_addr_ok = ({1'b0, ADDR} < DEPTH_V);

  assign LD_READY = (state == S_LOAD);
  assign RUN      = (state == S_RUN);
  assign ld_hs    = LD_VALID & LD_READY;
  assign fetch_go = RUN & RD_EN & ~REPROG;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    mem_we      = 1'b0;
    mem_wa      = clr_ptr;
    mem_wd      = FILL_WORD;
    case (state)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state_nxt   = S_LOAD;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + 1'b1;
        end
      end
      S_LOAD: begin
        // A dropped out-of-range word can still carry LAST.
        if (ld_hs && ld_addr_ok) begin
          mem_we = 1'b1;
          mem_wa = LD_ADDR[PTR_W-1:0];
          mem_wd = LD_DATA;
        end
        if (ld_hs && LD_LAST) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (REPROG) begin
          state_nxt = S_CLEAR;
        end
      end
      default: begin
        state_nxt   = S_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Single write port shared by the sweep and the loader; contents are never reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Q       <= '0;
      Q_VALID <= 1'b0;
    end else begin
      Q_VALID <= fetch_go;
      if (fetch_go) begin
        Q <= rd_addr_ok ? mem[ADDR[PTR_W-1:0]] : FILL_WORD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      LD_ERR <= 1'b0;
    end else if (RUN && REPROG) begin
      LD_ERR <= 1'b0;
    end else if (ld_hs && !ld_addr_ok) begin
      LD_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iram_prog.sv
// Bench for iram_prog: default 8x128 instance plus a 16x256 instance, checked against an array model.
module tb_iram_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Default instance: DATA_W=8, DEPTH=128
  logic       a_rst, a_ld_valid, a_ld_ready, a_ld_last, a_reprog, a_rd_en;
  logic       a_q_valid, a_run, a_ld_err;
  logic [7:0] a_ld_addr, a_ld_data, a_addr, a_q;

  // Wide instance: DATA_W=16, DEPTH=256
  logic        b_rst, b_ld_valid, b_ld_ready, b_ld_last, b_reprog, b_rd_en;
  logic        b_q_valid, b_run, b_ld_err;
  logic [7:0]  b_ld_addr, b_addr;
  logic [15:0] b_ld_data, b_q;

  iram_prog dut_a (
    .CLK(clk), .RESET(a_rst), .LD_VALID(a_ld_valid), .LD_READY(a_ld_ready),
    .LD_ADDR(a_ld_addr), .LD_DATA(a_ld_data), .LD_LAST(a_ld_last), .REPROG(a_reprog),
    .RD_EN(a_rd_en), .ADDR(a_addr), .Q(a_q), .Q_VALID(a_q_valid), .RUN(a_run), .LD_ERR(a_ld_err)
  );

  iram_prog #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .FILL_WORD(16'h0000)) dut_b (
    .CLK(clk), .RESET(b_rst), .LD_VALID(b_ld_valid), .LD_READY(b_ld_ready),
    .LD_ADDR(b_ld_addr), .LD_DATA(b_ld_data), .LD_LAST(b_ld_last), .REPROG(b_reprog),
    .RD_EN(b_rd_en), .ADDR(b_addr), .Q(b_q), .Q_VALID(b_q_valid), .RUN(b_run), .LD_ERR(b_ld_err)
  );

  // Reference contents: what a fetch must return, by address
  logic [7:0]  mdl8  [0:255];
  logic [15:0] mdl16 [0:255];

  function automatic logic [7:0] exp8(input int a);
    return (a < 128) ? mdl8[a] : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mdl8();
    for (int i = 0; i < 256; i++) mdl8[i] = 8'h00;
  endtask

  // Counts edges until LD_READY rises; returns the count (bounded)
  task automatic wait_ready_a(output int cnt);
    cnt = 0;
    while (!a_ld_ready && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic load_word(input int addr, input logic [7:0] data, input logic last);
    int w;
    a_ld_valid = 1'b1;
    a_ld_addr  = 8'(addr);
    a_ld_data  = data;
    a_ld_last  = last;
    w = 0;
    while (!a_ld_ready && w < 400) begin
      tick();
      w++;
    end
    if (!a_ld_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL load_timeout addr=%0d: LD_READY got %b want 1", addr, a_ld_ready);
    end else begin
      tick();
      if (addr < 128) mdl8[addr] = data;
    end
    a_ld_valid = 1'b0;
    a_ld_last  = 1'b0;
  endtask

  task automatic fetch8(input int addr);
    logic [7:0] e;
    e = exp8(addr);
    a_rd_en = 1'b1;
    a_addr  = 8'(addr);
    tick();
    a_rd_en = 1'b0;
    n_cmp++;
    if (a_q !== e || a_q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch addr=%0d: Q=%h vld=%b want Q=%h vld=1", addr, a_q, a_q_valid, e);
    end
  endtask

  task automatic fetch_burst(input int n, input bit seq);
    int         a;
    logic [7:0] last_e;
    last_e  = 8'h00;
    a_rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      a      = seq ? i : int'($urandom_range(0, 255));
      a_addr = 8'(a);
      tick();
      last_e = exp8(a);
      n_cmp++;
      if (a_q !== last_e || a_q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL burst addr=%0d: Q=%h vld=%b want Q=%h vld=1", a, a_q, a_q_valid, last_e);
      end
    end
    a_rd_en = 1'b0;
    tick();
    n_cmp++;
    if (a_q !== last_e || a_q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_idle: Q=%h vld=%b want Q=%h vld=0", a_q, a_q_valid, last_e);
    end
  endtask

  // REPROG together with a fetch, then wait out the sweep
  task automatic go_reprog();
    logic [7:0] prev;
    int         cnt;
    prev     = a_q;
    a_reprog = 1'b1;
    a_rd_en  = 1'b1;
    a_addr   = 8'd5;
    tick();
    a_reprog = 1'b0;
    a_rd_en  = 1'b0;
    n_cmp++;
    if (a_q_valid !== 1'b0 || a_run !== 1'b0 || a_ld_err !== 1'b0 || a_q !== prev) begin
      n_fail++;
      $display("FAIL reprog_entry: vld=%b run=%b err=%b Q=%h want 0 0 0 %h",
               a_q_valid, a_run, a_ld_err, a_q, prev);
    end
    clear_mdl8();
    wait_ready_a(cnt);
    n_cmp++;
    if (cnt != 128) begin
      n_fail++;
      $display("FAIL reprog_sweep_len: got %0d cycles want 128", cnt);
    end
  endtask

  task automatic test_reset();
    int cnt;
    bit saw_vld;
    a_rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (a_ld_ready !== 1'b0 || a_run !== 1'b0 || a_q !== 8'h00 || a_q_valid !== 1'b0 || a_ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b run=%b Q=%h vld=%b err=%b want all 0",
               a_ld_ready, a_run, a_q, a_q_valid, a_ld_err);
    end
    clear_mdl8();
    a_rst   = 1'b1;
    a_rd_en = 1'b1;
    a_addr  = 8'd3;
    cnt     = 0;
    saw_vld = 1'b0;
    while (!a_ld_ready && cnt < 1000) begin
      tick();
      cnt++;
      if (a_q_valid) saw_vld = 1'b1;
    end
    a_rd_en = 1'b0;
    n_cmp++;
    if (cnt != 128) begin
      n_fail++;
      $display("FAIL sweep_len: got %0d cycles want 128", cnt);
    end
    n_cmp++;
    if (saw_vld) begin
      n_fail++;
      $display("FAIL fetch_in_clear: Q_VALID got 1 want 0");
    end
  endtask

  task automatic test_empty_readback();
    load_word(0, 8'h00, 1'b1);
    n_cmp++;
    if (a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_run: RUN=%b want 1", a_run);
    end
    for (int i = 0; i < 128; i++) fetch8(i);
  endtask

  task automatic test_subtract();
    logic [7:0] prog [0:13];
    prog = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h50, 8'h50,
             8'hB4, 8'h70, 8'h60, 8'hC5, 8'h90, 8'h30, 8'hE0};
    go_reprog();
    for (int i = 0; i < 14; i++) load_word(i, prog[i], i == 13);
    n_cmp++;
    if (a_run !== 1'b1 || a_ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_run: RUN=%b LD_ERR=%b want 1 0", a_run, a_ld_err);
    end
    fetch8(7);
    n_cmp++;
    if (a_q !== 8'hB4) begin
      n_fail++;
      $display("FAIL sub_fetch7: Q=%h want b4", a_q);
    end
    fetch8(13);
    n_cmp++;
    if (a_q !== 8'hE0) begin
      n_fail++;
      $display("FAIL sub_fetch13: Q=%h want e0", a_q);
    end
    fetch8(20);
    fetch_burst(40, 1'b0);
  endtask

  task automatic test_gaps();
    bit         v;
    int         ad;
    logic [7:0] d;
    go_reprog();
    a_reprog = 1'b1;
    tick();
    a_reprog = 1'b0;
    n_cmp++;
    if (a_ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reprog_in_load: LD_READY=%b want 1", a_ld_ready);
    end
    for (int i = 0; i < 60; i++) begin
      v  = 1'($urandom_range(0, 1));
      ad = int'($urandom_range(0, 127));
      d  = 8'($urandom);
      a_ld_valid = v;
      a_ld_addr  = 8'(ad);
      a_ld_data  = d;
      tick();
      if (v) mdl8[ad] = d;
    end
    a_ld_valid = 1'b0;
    load_word(int'($urandom_range(0, 127)), 8'($urandom), 1'b1);
    n_cmp++;
    if (a_ld_err !== 1'b0 || a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_state: LD_ERR=%b RUN=%b want 0 1", a_ld_err, a_run);
    end
    fetch_burst(128, 1'b1);
  endtask

  task automatic test_oor();
    go_reprog();
    load_word(3, 8'h5A, 1'b0);
    n_cmp++;
    if (a_ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_pre: LD_ERR=%b want 0", a_ld_err);
    end
    load_word(200, 8'hFF, 1'b0);
    n_cmp++;
    if (a_ld_err !== 1'b1 || a_run !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_err: LD_ERR=%b RUN=%b want 1 0", a_ld_err, a_run);
    end
    a_rd_en = 1'b1;
    a_addr  = 8'd3;
    tick();
    a_rd_en = 1'b0;
    n_cmp++;
    if (a_q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_in_load: Q_VALID=%b want 0", a_q_valid);
    end
    load_word(250, 8'hAA, 1'b1);
    n_cmp++;
    if (a_run !== 1'b1 || a_ld_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_last: RUN=%b LD_ERR=%b want 1 1", a_run, a_ld_err);
    end
    fetch8(72);
    fetch8(200);
    fetch8(122);
    fetch8(3);
  endtask

  task automatic test_reprog();
    n_cmp++;
    if (a_ld_err !== 1'b1) begin
      n_fail++;
      $display("FAIL reprog_pre_err: LD_ERR=%b want 1", a_ld_err);
    end
    go_reprog();
    load_word(127, 8'h11, 1'b1);
    fetch8(3);
    fetch_burst(128, 1'b1);
  endtask

  task automatic test_reset_mid();
    int cnt;
    fetch8(127);
    a_rst = 1'b0;
    #1;
    n_cmp++;
    if (a_q !== 8'h00 || a_run !== 1'b0 || a_q_valid !== 1'b0 || a_ld_ready !== 1'b0 || a_ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_run: Q=%h run=%b vld=%b rdy=%b err=%b want all 0",
               a_q, a_run, a_q_valid, a_ld_ready, a_ld_err);
    end
    a_rst = 1'b1;
    clear_mdl8();
    for (int i = 0; i < 50; i++) tick();
    a_rst = 1'b0;
    #1;
    a_rst = 1'b1;
    wait_ready_a(cnt);
    n_cmp++;
    if (cnt != 128) begin
      n_fail++;
      $display("FAIL midsweep_len: got %0d cycles want 128", cnt);
    end
    load_word(9, 8'h99, 1'b0);
    load_word(210, 8'h21, 1'b0);
    a_rst = 1'b0;
    #1;
    n_cmp++;
    if (a_ld_ready !== 1'b0 || a_ld_err !== 1'b0 || a_run !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_load: rdy=%b err=%b run=%b want 0 0 0", a_ld_ready, a_ld_err, a_run);
    end
    a_rst = 1'b1;
    clear_mdl8();
    wait_ready_a(cnt);
    n_cmp++;
    if (cnt != 128) begin
      n_fail++;
      $display("FAIL midload_len: got %0d cycles want 128", cnt);
    end
    load_word(1, 8'h42, 1'b1);
    fetch8(9);
    fetch8(1);
  endtask

  task automatic test_wide();
    logic [7:0] prog [0:13];
    int         cnt;
    int         chk [0:4];
    logic [15:0] e;
    prog = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h50, 8'h50,
             8'hB4, 8'h70, 8'h60, 8'hC5, 8'h90, 8'h30, 8'hE0};
    chk  = '{7, 13, 20, 255, 0};
    for (int i = 0; i < 256; i++) mdl16[i] = 16'h0000;
    b_rst = 1'b1;
    cnt   = 0;
    while (!b_ld_ready && cnt < 1000) begin
      tick();
      cnt++;
    end
    n_cmp++;
    if (cnt != 256) begin
      n_fail++;
      $display("FAIL wide_sweep_len: got %0d cycles want 256", cnt);
    end
    for (int i = 0; i < 15; i++) begin
      b_ld_valid = 1'b1;
      b_ld_addr  = (i == 14) ? 8'd255 : 8'(i);
      b_ld_data  = (i == 14) ? 16'hBEEF : {8'($urandom), prog[i % 14]};
      b_ld_last  = (i == 14);
      mdl16[b_ld_addr] = b_ld_data;
      tick();
    end
    b_ld_valid = 1'b0;
    b_ld_last  = 1'b0;
    n_cmp++;
    if (b_run !== 1'b1 || b_ld_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_run: RUN=%b LD_ERR=%b want 1 0", b_run, b_ld_err);
    end
    for (int k = 0; k < 5; k++) begin
      e       = mdl16[chk[k]];
      b_rd_en = 1'b1;
      b_addr  = 8'(chk[k]);
      tick();
      b_rd_en = 1'b0;
      n_cmp++;
      if (b_q !== e || b_q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wide_fetch addr=%0d: Q=%h vld=%b want Q=%h vld=1", chk[k], b_q, b_q_valid, e);
      end
    end
    n_cmp++;
    if (b_q[7:0] !== 8'h40) begin
      n_fail++;
      $display("FAIL wide_fetch0_low: Q[7:0]=%h want 40", b_q[7:0]);
    end
  endtask

  initial begin
    a_rst = 1'b0; a_ld_valid = 1'b0; a_ld_last = 1'b0; a_reprog = 1'b0; a_rd_en = 1'b0;
    a_ld_addr = 8'h00; a_ld_data = 8'h00; a_addr = 8'h00;
    b_rst = 1'b0; b_ld_valid = 1'b0; b_ld_last = 1'b0; b_reprog = 1'b0; b_rd_en = 1'b0;
    b_ld_addr = 8'h00; b_ld_data = 16'h0000; b_addr = 8'h00;
    test_reset();
    test_empty_readback();
    test_subtract();
    test_gaps();
    test_oor();
    test_reprog();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
